// File: rtl/sar_search_4bit.sv
// Successive-approximation search engine driving comparator operand B.
// Recovers hidden operand A MSB first; exits early on equality.
module sar_search_4bit #(
  parameter int W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cmp_g,
  input  logic                     cmp_l,
  input  logic                     cmp_e,
  output logic [W-1:0]             probe,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             result,
  output logic                     err,
  output logic [$clog2(W+1)-1:0]   probe_cnt
);

  localparam int IW = (W > 2) ? $clog2(W) : 1;
  localparam int CW = $clog2(W+1);

  typedef enum logic {
    S_IDLE,
    S_PROBE
  } state_t;

  state_t          r_state, w_state_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic [W-1:0]    r_probe, w_probe_nx;
  logic [W-1:0]    r_result, w_result_nx;
  logic            r_err, w_err_nx;
  logic            r_done, w_done_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            w_onehot;
  logic            w_bad, w_eq, w_gt, w_lt;
  logic            w_last;
  logic [W-1:0]    w_bit;

  // exactly one of three flags: odd parity but not all three
  assign w_onehot = (cmp_g ^ cmp_l ^ cmp_e) &
                    ~(cmp_g & cmp_l & cmp_e);
  assign w_bad  = ~w_onehot;
  assign w_eq   = w_onehot & cmp_e;
  assign w_gt   = w_onehot & cmp_g;
  assign w_lt   = w_onehot & cmp_l;
  assign w_last = (r_idx == '0);
  assign w_bit  = w_last ? '0 :
                  (W'(1) << (r_idx - IW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= IW'(W-1);
      r_probe  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_probe  <= w_probe_nx;
      r_result <= w_result_nx;
      r_err    <= w_err_nx;
      r_done   <= w_done_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_probe_nx  = r_probe;
    w_result_nx = r_result;
    w_err_nx    = r_err;
    w_done_nx   = 1'b0;
    w_cnt_nx    = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_result_nx = '0;
          w_err_nx    = 1'b0;
          w_cnt_nx    = '0;
          w_idx_nx    = IW'(W-1);
          w_probe_nx  = {1'b1, {(W-1){1'b0}}};
          w_state_nx  = S_PROBE;
        end
      end
      S_PROBE: begin
        w_cnt_nx = r_cnt + CW'(1);
        unique case (1'b1)
          w_bad: begin
            w_err_nx   = 1'b1;
            w_done_nx  = 1'b1;
          end
          w_eq: begin
            w_result_nx = r_probe;
            w_done_nx   = 1'b1;
          end
          w_gt: begin
            if (w_last) begin
              w_err_nx  = 1'b1;
              w_done_nx = 1'b1;
            end else begin
              w_result_nx = r_probe;
              w_probe_nx  = r_probe | w_bit;
              w_idx_nx    = r_idx - IW'(1);
            end
          end
          w_lt: begin
            // at bit 0, A == result by elimination
            if (w_last) begin
              w_done_nx = 1'b1;
            end else begin
              w_probe_nx = r_result | w_bit;
              w_idx_nx   = r_idx - IW'(1);
            end
          end
          default: begin
            w_done_nx = 1'b0;
          end
        endcase
        if (w_done_nx) begin
          w_probe_nx = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign probe     = r_probe;
  assign busy      = (r_state == S_PROBE);
  assign done      = r_done;
  assign result    = r_result;
  assign err       = r_err;
  assign probe_cnt = r_cnt;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Scoreboard bench for sar_search_4bit with a behavioural comparator
// whose flags can be forced to exercise the error paths.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_g, cmp_l, cmp_e;
  logic [3:0] probe, result;
  logic       busy, done, err;
  logic [2:0] probe_cnt;

  logic [3:0] a = '0;
  logic       ovr_gl = 1'b0;
  logic       ovr_g_en = 1'b0;
  logic [3:0] ovr_g_val = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  res;
    logic        e;
    logic [2:0]  cnt;
    int          lat;
    int          st;
    logic [15:0] tr;
  } exp_t;

  exp_t sb[$];

  sar_search_4bit #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmp_g     (cmp_g),
    .cmp_l     (cmp_l),
    .cmp_e     (cmp_e),
    .probe     (probe),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .probe_cnt (probe_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    cmp_g = (a > probe);
    cmp_l = (a < probe);
    cmp_e = (a == probe);
    if (ovr_gl) begin
      cmp_g = 1'b1;
      cmp_l = 1'b1;
    end
    if (ovr_g_en && probe == ovr_g_val) begin
      cmp_g = 1'b1;
      cmp_l = 1'b0;
      cmp_e = 1'b0;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] tr;
    exp_t        e;
    tr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tr = '0;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("err", 32'(err), 32'(e.e));
            chk("probe_cnt", 32'(probe_cnt), 32'(e.cnt));
            chk("latency", 32'(cyc - e.st), 32'(e.lat));
            chk("probe_trace", 32'(tr), 32'(e.tr));
          end
          tr = '0;
        end
        if (busy) tr = {tr[11:0], probe};
      end
    end
  endtask

  task automatic push(input logic [3:0] r, input logic e,
                      input logic [2:0] c, input int l,
                      input logic [15:0] t);
    exp_t x;
    x.res = r;
    x.e   = e;
    x.cnt = c;
    x.lat = l;
    x.st  = cyc + 1;
    x.tr  = t;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic search(input logic [3:0] av, input logic [3:0] r,
                        input logic e, input logic [2:0] c,
                        input int l, input logic [15:0] t);
    a = av;
    start = 1'b1;
    push(r, e, c, l, t);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_probe"}, 32'(probe), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cnt"}, 32'(probe_cnt), 32'd0);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    search(4'd11, 4'd11, 1'b0, 3'd4, 4, 16'h8CAB);
    search(4'd8,  4'd8,  1'b0, 3'd1, 1, 16'h0008);
    search(4'd0,  4'd0,  1'b0, 3'd4, 4, 16'h8421);
    search(4'd15, 4'd15, 1'b0, 3'd4, 4, 16'h8CEF);

    ovr_gl = 1'b1;
    search(4'd7, 4'd0, 1'b1, 3'd1, 1, 16'h0008);
    ovr_gl = 1'b0;

    // G forced on the final probe: impossible under the invariant
    ovr_g_en  = 1'b1;
    ovr_g_val = 4'd9;
    a = 4'd9;
    start = 1'b1;
    push(4'd8, 1'b1, 3'd4, 4, 16'h8CA9);
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_idle();
    ovr_g_en = 1'b0;
    @(negedge clk);

    a = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    search(4'd5, 4'd5, 1'b0, 3'd4, 4, 16'h8465);

    a = 4'd6;
    start = 1'b1;
    push(4'd6, 1'b0, 3'd3, 3, 16'h0846);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("held_done_seen", 32'(done), 32'd1);
    a = 4'd3;
    push(4'd3, 1'b0, 3'd4, 4, 16'h8423);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_probe", 32'(probe), 32'd8);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
